// File: rtl/divisor_control.sv
// Sequential restoring divider: one quotient bit per CMP/GAP pair, MSB first,
// with each bit edge-coded on o_bit for the downstream shift register.
module divisor_control #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [1:0]   o_bit,
  output logic         o_clr,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CMP,
    GAP,
    DONE
  } state_t;

  state_t       state;
  logic [CW-1:0] idx;

  logic [N-1:0] d_reg;
  logic [N-1:0] v_reg;
  logic [N-1:0] q_reg;
  logic [N:0]   r_reg;

  logic [N:0]   trial;
  logic         fits;
  logic [N:0]   r_next;
  logic         r_msb_unused;

  function automatic logic trial_fits(input logic [N:0] t, input logic [N-1:0] v);
    return t >= {1'b0, v};
  endfunction

  function automatic logic [N:0] restore_step(input logic [N:0] t, input logic [N-1:0] v);
    if (t >= {1'b0, v}) begin
      return t - {1'b0, v};
    end
    return t;
  endfunction

  // Shift in the next dividend bit; compare/subtract at N+1 bits.
  assign trial        = {r_reg[N-1:0], d_reg[idx]};
  assign fits         = trial_fits(trial, v_reg);
  assign r_next       = restore_step(trial, v_reg);
  assign r_msb_unused = r_reg[N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= LAST_IDX;
      o_bit       <= 2'b00;
      o_clr       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done  <= 1'b0;
      o_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            busy        <= 1'b1;
            o_clr       <= 1'b1;
            div_by_zero <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          if (v_reg == '0) begin
            state       <= DONE;
            div_by_zero <= 1'b1;
          end else begin
            state <= CMP;
            idx   <= LAST_IDX;
          end
        end
        CMP: begin
          o_bit <= fits ? 2'b10 : 2'b01;
          state <= GAP;
        end
        // The 00 gap guarantees a fresh rising edge even for repeated bits.
        GAP: begin
          o_bit <= 2'b00;
          if (idx == '0) begin
            state <= DONE;
          end else begin
            idx   <= idx - 1'b1;
            state <= CMP;
          end
        end
        DONE: begin
          done      <= 1'b1;
          quotient  <= q_reg;
          remainder <= r_reg[N-1:0];
          o_bit     <= 2'b00;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          d_reg <= dividend;
          v_reg <= divisor;
          r_reg <= '0;
          q_reg <= '0;
        end
      end
      LOAD: begin
        if (v_reg == '0) begin
          r_reg <= {1'b0, d_reg};
        end
      end
      CMP: begin
        r_reg      <= r_next;
        q_reg[idx] <= fits;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_divisor_control.sv
// Randomized and directed checks of divisor_control against a plain-arithmetic
// model of the quotient bit stream, latency and final results.
module tb_divisor_control;

  localparam int N = 8;
  localparam int NC = 2 * N + 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [1:0]   o_bit;
  logic         o_clr;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]   tr_bit  [0:63];
  logic         tr_clr  [0:63];
  logic         tr_done [0:63];
  logic         tr_busy [0:63];
  logic         tr_dz   [0:63];
  logic [N-1:0] tr_q    [0:63];
  logic [N-1:0] tr_r    [0:63];

  divisor_control #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .o_bit       (o_bit),
    .o_clr       (o_clr),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic record(input int c);
    tr_bit[c]  = o_bit;
    tr_clr[c]  = o_clr;
    tr_done[c] = done;
    tr_busy[c] = busy;
    tr_dz[c]   = div_by_zero;
    tr_q[c]    = quotient;
    tr_r[c]    = remainder;
  endtask

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
  endtask

  // Index c holds the outputs seen after the c-th edge following the start edge (c=0).
  task automatic capture(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      step();
      record(c);
      if (c == 0) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    step();
    step();
    n_cmp += 7;
    if (o_bit !== 2'b00) begin n_bad++; $display("FAIL reset_o_bit: got %b expected 00", o_bit); end
    if (o_clr !== 1'b0) begin n_bad++; $display("FAIL reset_o_clr: got %b expected 0", o_clr); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    if (quotient !== '0) begin n_bad++; $display("FAIL reset_quotient: got %0d expected 0", quotient); end
    if (remainder !== '0) begin n_bad++; $display("FAIL reset_remainder: got %0d expected 0", remainder); end
    if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    reset = 1'b0;
    step();
    step();
    n_cmp++;
    if (busy !== 1'b0 || o_clr !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy=%b o_clr=%b expected 0 0", busy, o_clr);
    end
  endtask

  task automatic test_division();
    logic [N-1:0] ta [4];
    logic [N-1:0] tb [4];
    logic [N-1:0] a, b, eq, er;
    logic         ez;
    logic [1:0]   exp_bit;
    int           done_at;
    ta = '{8'd100, 8'd255, 8'd5, 8'd42};
    tb = '{8'd7, 8'd1, 8'd9, 8'd0};
    for (int v = 0; v < 28; v++) begin
      if (v < 4) begin
        a = ta[v];
        b = tb[v];
      end else begin
        a = N'($urandom_range(0, 255));
        b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 255));
      end
      if (b != '0) begin
        eq = a / b; er = a % b; ez = 1'b0; done_at = 2 * N + 2;
      end else begin
        eq = '0; er = a; ez = 1'b1; done_at = 2;
      end
      launch(a, b);
      capture(NC);
      for (int c = 0; c < NC; c++) begin
        exp_bit = 2'b00;
        if (b != '0 && c >= 2 && c <= 2 * N + 1 && (c % 2) == 0)
          exp_bit = eq[N - 1 - (c - 2) / 2] ? 2'b10 : 2'b01;
        n_cmp += 4;
        if (tr_bit[c] !== exp_bit) begin
          n_bad++;
          $display("FAIL o_bit %0d/%0d c=%0d: got %b expected %b", a, b, c, tr_bit[c], exp_bit);
        end
        if (tr_clr[c] !== (c == 0)) begin
          n_bad++;
          $display("FAIL o_clr %0d/%0d c=%0d: got %b expected %b", a, b, c, tr_clr[c], c == 0);
        end
        if (tr_done[c] !== (c == done_at)) begin
          n_bad++;
          $display("FAIL done %0d/%0d c=%0d: got %b expected %b", a, b, c, tr_done[c], c == done_at);
        end
        if (tr_busy[c] !== (c <= done_at)) begin
          n_bad++;
          $display("FAIL busy %0d/%0d c=%0d: got %b expected %b", a, b, c, tr_busy[c], c <= done_at);
        end
      end
      n_cmp += 4;
      if (tr_dz[0] !== 1'b0) begin n_bad++; $display("FAIL dbz_cleared %0d/%0d: got %b expected 0", a, b, tr_dz[0]); end
      if (quotient !== eq) begin n_bad++; $display("FAIL quotient %0d/%0d: got %0d expected %0d", a, b, quotient, eq); end
      if (remainder !== er) begin n_bad++; $display("FAIL remainder %0d/%0d: got %0d expected %0d", a, b, remainder, er); end
      if (div_by_zero !== ez) begin n_bad++; $display("FAIL dbz %0d/%0d: got %b expected %b", a, b, div_by_zero, ez); end
    end
  endtask

  task automatic test_reset_abort();
    launch(8'd200, 8'd3);
    step();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) step();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    #1;
    n_cmp += 4;
    if (o_bit !== 2'b00) begin n_bad++; $display("FAIL abort_cmp_o_bit: got %b expected 00", o_bit); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_cmp_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL abort_cmp_done: got %b expected 0", done); end
    if (quotient !== '0) begin n_bad++; $display("FAIL abort_cmp_quotient: got %0d expected 0", quotient); end
    step();
    reset = 1'b0;

    launch(8'd200, 8'd3);
    step();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) step();
    n_cmp++;
    if (o_bit !== 2'b01) begin n_bad++; $display("FAIL abort_gap_code: got %b expected 01", o_bit); end
    reset = 1'b1;
    #1;
    n_cmp += 2;
    if (o_bit !== 2'b00) begin n_bad++; $display("FAIL abort_gap_o_bit: got %b expected 00", o_bit); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_gap_busy: got %b expected 0", busy); end
    step();
    reset = 1'b0;

    launch(8'd200, 8'd3);
    capture(NC);
    n_cmp += 4;
    if (tr_done[2 * N + 2] !== 1'b1) begin n_bad++; $display("FAIL rerun_done: got %b expected 1", tr_done[2 * N + 2]); end
    if (quotient !== 8'd66) begin n_bad++; $display("FAIL rerun_quotient: got %0d expected 66", quotient); end
    if (remainder !== 8'd2) begin n_bad++; $display("FAIL rerun_remainder: got %0d expected 2", remainder); end
    if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL rerun_dbz: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] q1, q2;
    logic [1:0]   exp_bit;
    int           rel;
    q1 = 8'd14;
    q2 = 8'd22;
    launch(8'd100, 8'd7);
    for (int c = 0; c < 40; c++) begin
      step();
      record(c);
      case (c)
        0:  start = 1'b0;
        5:  launch(8'd50, 8'd5);
        6:  start = 1'b0;
        17: launch(8'd200, 8'd9);
        37: start = 1'b0;
        default: begin end
      endcase
    end
    for (int c = 0; c < 40; c++) begin
      exp_bit = 2'b00;
      rel = (c >= 19) ? c - 19 : c;
      if (rel >= 2 && rel <= 2 * N + 1 && (rel % 2) == 0) begin
        if (c >= 19) exp_bit = q2[N - 1 - (rel - 2) / 2] ? 2'b10 : 2'b01;
        else exp_bit = q1[N - 1 - (rel - 2) / 2] ? 2'b10 : 2'b01;
      end
      n_cmp += 3;
      if (tr_bit[c] !== exp_bit) begin
        n_bad++;
        $display("FAIL b2b_o_bit c=%0d: got %b expected %b", c, tr_bit[c], exp_bit);
      end
      if (tr_clr[c] !== (c == 0 || c == 19)) begin
        n_bad++;
        $display("FAIL b2b_o_clr c=%0d: got %b expected %b", c, tr_clr[c], c == 0 || c == 19);
      end
      if (tr_done[c] !== (c == 18 || c == 37)) begin
        n_bad++;
        $display("FAIL b2b_done c=%0d: got %b expected %b", c, tr_done[c], c == 18 || c == 37);
      end
    end
    n_cmp += 6;
    if (tr_q[18] !== 8'd14) begin n_bad++; $display("FAIL b2b_q1: got %0d expected 14", tr_q[18]); end
    if (tr_r[18] !== 8'd2) begin n_bad++; $display("FAIL b2b_r1: got %0d expected 2", tr_r[18]); end
    if (tr_busy[19] !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_restart: got %b expected 1", tr_busy[19]); end
    if (tr_q[37] !== 8'd22) begin n_bad++; $display("FAIL b2b_q2: got %0d expected 22", tr_q[37]); end
    if (tr_r[37] !== 8'd2) begin n_bad++; $display("FAIL b2b_r2: got %0d expected 2", tr_r[37]); end
    if (tr_busy[39] !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_end: got %b expected 0", tr_busy[39]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_division();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/divisor_control.md
Name: divisor_control

Overview:
- Sequential restoring-division engine for the divider datapath, sitting directly upstream of the quotient output register stage.
- Divides an unsigned N-bit dividend by an unsigned N-bit divisor, MSB first, one quotient bit per iteration.
- Each quotient bit goes out on a 2-bit edge-coded bus (10 = bit 1, 01 = bit 0, 00 = no bit). The downstream stage shifts each bit into its register on a rising edge of either bus line.
- Also reports the final quotient, the remainder and a divide-by-zero flag.

Parameters:
- N, 8, operand/quotient/remainder width in bits (valid range 2..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  N  unsigned dividend; captured on the accepted start edge.
- divisor  input  N  unsigned divisor; captured on the accepted start edge.
- o_bit  output  2  quotient bit code to downstream: 00 none, 10 = 1, 01 = 0; 11 never driven.
- o_clr  output  1  one-cycle pulse telling downstream to clear its register before the first bit.
- busy  output  1  high from LOAD through DONE inclusive.
- done  output  1  one-cycle pulse when the result is valid.
- quotient  output  N  final quotient; holds until the next accepted start.
- remainder  output  N  final remainder; holds until the next accepted start.
- div_by_zero  output  1  set when divisor == 0; holds until the next accepted start.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE.
  - o_bit = 00; o_clr, busy, done, div_by_zero = 0; quotient, remainder = 0; iteration counter = N-1.
  - Reset mid-operation aborts immediately. o_bit drops to 00 in the same instant, with no partial bit code left asserted.
- All outputs are registered; no combinational path from any input to any output.
- IDLE:
  - Outputs hold their previous values.
  - If start = 1 at a clock edge: capture dividend into D and divisor into V; clear partial remainder R (N+1 bits), quotient Q, and div_by_zero; go to LOAD.
- LOAD (1 cycle):
  - o_clr = 1, busy = 1.
  - If V == 0: next state is DONE with div_by_zero = 1, quotient = 0, remainder = D. No bit codes are emitted.
  - Otherwise: next state is CMP with counter i = N-1.
- CMP (1 cycle per bit):
  - Compute T = {R[N-1:0], D[i]}.
  - If T >= V: R <= T - V, Q[i] <= 1, o_bit <= 10.
  - Else: R <= T, Q[i] <= 0, o_bit <= 01.
  - Next state: GAP.
- GAP (1 cycle per bit):
  - o_bit <= 00, so the downstream stage sees a fresh rising edge for every bit, including repeated equal bits.
  - If i == 0: go to DONE. Otherwise decrement i and return to CMP.
- DONE (1 cycle):
  - done = 1; quotient <= Q; remainder <= R[N-1:0]; o_bit = 00.
  - Next state: IDLE. busy falls on the next edge.
- Latency:
  - Nonzero divisor: done is high in the cycle 2N+2 edges after the start-sampling edge (N=8: 18).
  - Zero divisor: 2 edges.
- Each bit code is asserted for exactly 1 cycle, followed by exactly 1 cycle of 00. Bits are emitted MSB first, N codes total.
- start while busy (LOAD/CMP/GAP/DONE) is ignored; no queuing. Operand changes while busy have no effect.
- start held high continuously: a new division begins on the first edge back in IDLE, one cycle after DONE.
- Width rules:
  - R carries N+1 bits so the shift never overflows.
  - The comparison and subtraction are done at N+1 bits, with V zero-extended.
  - Invariant: remainder < divisor whenever divisor != 0.
- o_bit and o_clr are never high in the same cycle.

Test Plan:
- N=8, dividend=100, divisor=7:
  - o_clr pulse, then o_bit sequence 01,00,01,00,01,00,01,00,10,00,10,00,10,00,01,00.
  - done at edge 18, quotient=14, remainder=2, div_by_zero=0.
- dividend=255, divisor=1 -> eight 10 codes each separated by 00; quotient=255, remainder=0.
- dividend=5, divisor=9 -> eight 01 codes; quotient=0, remainder=5.
- dividend=42, divisor=0 -> o_clr pulse, no non-00 codes, done at edge 2; div_by_zero=1, quotient=0, remainder=42.
- Start 200/3, assert reset during the 4th CMP -> o_bit=00 and busy=0 immediately. Then start 200/3 again -> quotient=66, remainder=2.
- Start 100/7, pulse start with 50/5 at edge 6, then hold start high after done:
  - The edge-6 request is ignored: result is 14/2.
  - A second division of the currently presented operands begins exactly one cycle after the done pulse.
